// File: rtl/maj_sample_rx_pkg.sv
// Shared definitions for the majority-sampled serial receiver:
// FSM encodings and counter width helpers.
package maj_sample_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int SAMPLES_PER_BIT = 3;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maj3_vote.sv
// Combinational 2-of-3 majority voter.
module maj3_vote (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic m
);

  assign m = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/maj_sample_rx.sv
// Serial-bit capture controller: three spaced samples per bit, resolved by
// majority vote, assembled into an NBITS word and offered on valid/ready.
module maj_sample_rx
  import maj_sample_rx_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int GAP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din,
  output logic             busy,
  output logic [NBITS-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int GAP_W = cnt_width(GAP);
  localparam int BIT_W = cnt_width(NBITS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [1:0]       SMP_LAST = 2'(SAMPLES_PER_BIT - 1);

  state_t state;
  state_t state_next;

  logic [GAP_W-1:0] gap_cnt;
  logic [1:0]       samp_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             s0;
  logic             s1;
  logic [NBITS-1:0] data_q;
  logic             err_q;

  logic accept;
  logic sample_tick;
  logic resolve;
  logic last_bit;
  logic voted;
  logic unanimous;

  maj3_vote u_vote (
    .a (s0),
    .b (s1),
    .c (din),
    .m (voted)
  );

  // Handshake: valid is high for the whole HOLD state and data/err are frozen
  // there; a transfer happens on any edge with valid & ready, after which the
  // block returns to IDLE. ready has no effect in any other state.
  assign accept      = (state == ST_IDLE) && start;
  assign sample_tick = (state == ST_SAMPLE) && (gap_cnt == GAP_LAST);
  assign resolve     = sample_tick && (samp_cnt == SMP_LAST);
  assign last_bit    = (bit_cnt == BIT_LAST);
  assign unanimous   = (s0 == s1) && (s1 == din);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (resolve && last_bit) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The gap counter wraps on the sampling edge itself, so GAP=1 samples every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt  <= '0;
      samp_cnt <= '0;
      bit_cnt  <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
    end else if (accept) begin
      gap_cnt  <= '0;
      samp_cnt <= '0;
      bit_cnt  <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
    end else if (state == ST_SAMPLE) begin
      if (sample_tick) begin
        gap_cnt <= '0;
        case (samp_cnt)
          2'd0: begin
            s0       <= din;
            samp_cnt <= 2'd1;
          end
          2'd1: begin
            s1       <= din;
            samp_cnt <= 2'd2;
          end
          default: begin
            samp_cnt <= '0;
            bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
          end
        endcase
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  // data/err survive the handshake and are only cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (resolve) begin
      data_q[bit_cnt] <= voted;
      err_q           <= err_q | ~unanimous;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign valid     = (state == ST_HOLD);
  assign data      = data_q;
  assign err       = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_maj_sample_rx.sv
// Directed bench for maj_sample_rx at NBITS=8, GAP=4: reset, clean/glitched
// frames, backpressure, ignored starts, back-to-back and mid-frame reset.
module tb_maj_sample_rx;

  localparam int NB  = 8;
  localparam int GP  = 4;
  localparam int NS  = 3 * NB;
  localparam int LAT = NS * GP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          din;
  logic          ready;
  logic          busy;
  logic          valid;
  logic          err;
  logic [NB-1:0] data;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  maj_sample_rx #(.NBITS(NB), .GAP(GP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .din       (din),
    .busy      (busy),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Sample vector: bit i owns entries 3i..3i+2, in capture order.
  function automatic logic [NS-1:0] clean_smp(input logic [NB-1:0] w);
    logic [NS-1:0] s;
    for (int i = 0; i < NB; i++)
      for (int k = 0; k < 3; k++)
        s[3*i+k] = w[i];
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts a frame at the next edge (edge 0) and drives samples up to edge
  // LAT-1; returns 1 time unit after edge LAT-1 with the last sample on din.
  task automatic run_frame(input logic [NS-1:0] smp, input bit noise);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e < LAT; e++) begin
      din = (e % GP == 0) ? smp[e/GP-1] : 1'($urandom_range(0, 1));
      if (noise) start = 1'($urandom_range(0, 1));
      step();
    end
    din   = smp[NS-1];
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'($urandom_range(0, 1));
    din   = 1'($urandom_range(0, 1));
    ready = 1'($urandom_range(0, 1));
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, valid, err, data} !== {3'b000, 8'h00}) begin
      bad++;
      $display("FAIL reset_async: got busy=%b valid=%b err=%b data=%h expected 0 0 0 00", busy, valid, err, data);
    end
    step();
    step();
    start = 1'b0;
    ready = 1'b0;
    rst_n = 1'b1;
    step();
    total++;
    if ({busy, valid, err, data} !== {3'b000, 8'h00}) begin
      bad++;
      $display("FAIL reset_release: got busy=%b valid=%b err=%b data=%h expected 0 0 0 00", busy, valid, err, data);
    end
  endtask

  task automatic frame_check(input string name, input logic [NS-1:0] smp,
                             input logic [NB-1:0] exp_data, input logic exp_err);
    ready = 1'b0;
    run_frame(smp, 1'b0);
    total++;
    if ({busy, valid} !== 2'b10) begin
      bad++;
      $display("FAIL %s_pre: got busy=%b valid=%b expected 1 0 before edge %0d", name, busy, valid, LAT);
    end
    step();
    total++;
    if ({valid, data, err} !== {1'b1, exp_data, exp_err}) begin
      bad++;
      $display("FAIL %s_result: got valid=%b data=%h err=%b expected 1 %h %b", name, valid, data, err, exp_data, exp_err);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    total++;
    if ({valid, busy, data, err} !== {2'b00, exp_data, exp_err}) begin
      bad++;
      $display("FAIL %s_handshake: got valid=%b busy=%b data=%h err=%b expected 0 0 %h %b", name, valid, busy, data, err, exp_data, exp_err);
    end
  endtask

  task automatic test_clean();
    frame_check("clean", clean_smp(8'hA5), 8'hA5, 1'b0);
  endtask

  task automatic test_glitch();
    logic [NS-1:0] s;
    s = clean_smp(8'hA5);
    for (int i = 0; i < NB; i++) s[3*i+1] = ~s[3*i+1];
    frame_check("glitch", s, 8'hA5, 1'b1);
  endtask

  task automatic test_double_flip();
    logic [NS-1:0] s;
    s = clean_smp(8'hA5);
    s[9]  = 1'b1;
    s[10] = 1'b1;
    frame_check("double_flip", s, 8'hAD, 1'b1);
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    run_frame(clean_smp(8'h5A), 1'b1);
    step();
    total++;
    if ({valid, busy, data, err} !== {2'b11, 8'h5A, 1'b0}) begin
      bad++;
      $display("FAIL bp_first: got valid=%b busy=%b data=%h err=%b expected 1 1 5a 0", valid, busy, data, err);
    end
    for (int c = 0; c < 10; c++) begin
      start = (c % 2 == 0);
      din   = 1'($urandom_range(0, 1));
      step();
      total++;
      if ({valid, busy, data, err} !== {2'b11, 8'h5A, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold_%0d: got valid=%b busy=%b data=%h err=%b expected 1 1 5a 0", c, valid, busy, data, err);
      end
    end
    ready = 1'b1;
    start = 1'b1;
    step();
    ready = 1'b0;
    start = 1'b0;
    total++;
    if ({valid, busy, dbg_state} !== {2'b00, 2'd0}) begin
      bad++;
      $display("FAIL bp_handshake: got valid=%b busy=%b state=%0d expected 0 0 0", valid, busy, dbg_state);
    end
  endtask

  // Starts the next frame one cycle after the handshake, with ready held high.
  task automatic test_back_to_back();
    ready = 1'b1;
    run_frame(clean_smp(8'hC3), 1'b0);
    total++;
    if ({busy, valid} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_pre: got busy=%b valid=%b expected 1 0", busy, valid);
    end
    step();
    total++;
    if ({valid, data, err} !== {1'b1, 8'hC3, 1'b0}) begin
      bad++;
      $display("FAIL b2b_result: got valid=%b data=%h err=%b expected 1 c3 0", valid, data, err);
    end
    step();
    total++;
    if ({valid, busy, data} !== {2'b00, 8'hC3}) begin
      bad++;
      $display("FAIL b2b_auto_handshake: got valid=%b busy=%b data=%h expected 0 0 c3", valid, busy, data);
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic saw_valid;
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      din = 1'($urandom_range(0, 1));
      step();
    end
    total++;
    if ({busy, valid} !== 2'b10) begin
      bad++;
      $display("FAIL mid_before: got busy=%b valid=%b expected 1 0", busy, valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, valid, err, data} !== {3'b000, 8'h00}) begin
      bad++;
      $display("FAIL mid_async: got busy=%b valid=%b err=%b data=%h expected 0 0 0 00", busy, valid, err, data);
    end
    step();
    step();
    rst_n     = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < LAT; c++) begin
      din = 1'($urandom_range(0, 1));
      step();
      saw_valid = saw_valid | valid | busy;
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_valid: got busy_or_valid_seen=%b expected 0", saw_valid);
    end
    frame_check("after_reset", clean_smp(8'h3C), 8'h3C, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    din   = 1'b0;
    ready = 1'b0;
    test_reset();
    test_clean();
    test_glitch();
    test_double_flip();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maj_sample_rx.md
# maj_sample_rx

Serial-bit capture controller built around a 3-input majority voter. On a start request it samples a serial line three times per bit at a fixed spacing and resolves each bit by 2-of-3 majority. It assembles NBITS voted bits into a parallel word and presents the word on a valid/ready handshake. The block sits between a noisy single-wire input and the parallel consumer logic, and sequences the shared voter.

## Interface
Parameters:
- NBITS, 8, bits per frame (≥1)
- GAP, 4, clock cycles between consecutive samples (≥1)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame request; accepted only in IDLE
- din  in  1  serial input line, synchronous to clk
- busy  out  1  high from start acceptance until handshake completes
- data  out  NBITS  voted frame; first-resolved bit in data[0]
- valid  out  1  data available
- ready  in  1  consumer accepts data when valid & ready
- err  out  1  sticky per frame: some bit's three samples were not unanimous

## Operation
- States: IDLE, SAMPLE, HOLD.
- IDLE, start=1: go to SAMPLE, busy=1, clear data/err/counters.
- SAMPLE:
  - Gap counter counts GAP cycles per sample. Sample counter runs 0..2. Bit counter runs 0..NBITS-1.
  - Samples 0 and 1 of a bit are stored in registers.
  - On sample 2, the voter takes (s0, s1, live din) and the result is written to data[bit] at that same edge.
  - err is set at that edge if s0, s1 and din are not all equal.
  - After the last bit, go to HOLD.
- HOLD:
  - valid=1; data and err held stable.
  - On valid & ready: go to IDLE, valid=0, busy=0.
  - data and err keep their values until the next start acceptance.
- start is ignored outside IDLE, including in the HOLD handshake cycle.
- ready is ignored outside HOLD.
- No frame abort other than reset.

## Timing
- Reset (async assert): state=IDLE; busy=0, valid=0, err=0, data=0; all counters 0. Deassertion takes effect at the next clk edge.
- Start acceptance edge = edge 0.
- Sample j (j=1..3·NBITS) captures din at edge j·GAP.
- Bit i is resolved at edge 3·(i+1)·GAP.
- valid rises after edge 3·NBITS·GAP. Latency is 3·NBITS·GAP cycles; default parameters give 96 cycles.
- Handshake:
  - If ready is already high, the handshake completes at the first edge where valid=1.
  - valid and busy fall after the handshake edge.
  - A new start is accepted no earlier than the following edge.
- Back-to-back frames: minimum period is 3·NBITS·GAP+2 cycles.
- Reset mid-frame: immediate abort. No valid is ever asserted for the aborted frame.
- GAP=1: a sample is taken every cycle. The gap counter must not skip or double-count.

## Structure
- Shared header/package holds:
  - state encodings (IDLE, SAMPLE, HOLD)
  - counter width computations for NBITS and GAP (clog2-based)
- Sub-module maj3_vote: combinational 2-of-3 majority, inputs a, b, c, output m. It is the only voting logic, instantiated once.
- Top level holds the FSM, the three counters, the two sample registers, the data register and the err flag.

## Test plan
Defaults NBITS=8, GAP=4.
- Reset: assert rst_n=0 with random inputs -> busy=0, valid=0, err=0, data=0x00, asynchronously.
- Clean frame: start, then din held per bit window to encode 0xA5 -> valid at cycle 96, data=0xA5, err=0.
- Single glitch: same frame, middle sample of every bit inverted -> data=0xA5, err=1.
- Double flip: bit 3 has two of three samples at 1 -> data=0xAD, err=1.
- Backpressure and ignored start:
  - ready low for 10 cycles after valid -> data and valid stable throughout.
  - start pulses during SAMPLE and HOLD -> ignored.
  - ready=1 -> valid=0 and busy=0 next cycle.
  - start one cycle later -> new frame accepted.
- Reset mid-frame: rst_n low at cycle 40 -> outputs at reset values, no valid. New start -> 0x3C frame completes correctly at cycle 96.
